// File: rtl/my_xor2_rr_arbiter.sv
// my_xor2_rr_arbiter
// Shares one registered XOR unit (operands sampled when XOR_CE=1, result on
// XOR_O one cycle later, held while XOR_CE=0) among NREQ requesters.
// One transaction is in flight at a time: IDLE grants and latches, ISSUE
// pulses the unit's clock enable, RESP presents the result until accepted.
// Build option: define MY_XOR2_ARB_FIXED_PRIO_EN for fixed priority (lowest
// index wins, no rotating pointer); default is round-robin.
module my_xor2_rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic [NREQ-1:0] REQ_VALID,
   input  logic [NREQ-1:0] REQ_A,
   input  logic [NREQ-1:0] REQ_B,
   output logic [NREQ-1:0] REQ_READY,
   output logic            XOR_CE,
   output logic            XOR_A,
   output logic            XOR_B,
   input  logic            XOR_O,
   output logic            RSP_VALID,
   output logic            RSP_DATA,
   output logic [IDW-1:0]  RSP_ID,
   input  logic            RSP_READY
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_RESP  = 2'd2;

   logic [1:0]      state;
   logic [1:0]      state_nxt;
   logic            op_a;
   logic            op_b;
   logic [IDW-1:0]  id;
   logic [IDW-1:0]  start;
   logic [NREQ-1:0] rot;
   logic [IDW-1:0]  gnt;
   logic            gnt_vld;
   logic            accept;

`ifdef MY_XOR2_ARB_FIXED_PRIO_EN
   assign start = '0;
`else
   logic [IDW-1:0] ptr;

   function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] cur);
      if (cur == IDW'(NREQ - 1))
         return '0;
      else
         return cur + 1'b1;
   endfunction

   // Rotate the search start to the requester after the one just served
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)
         ptr <= '0;
      else if (state == S_RESP && RSP_READY)
         ptr <= next_id(id);
   end

   assign start = ptr;
`endif

   // Find the first valid requester at or above start, wrapping around
   always_comb begin
      rot     = NREQ'({REQ_VALID, REQ_VALID} >> start);
      gnt     = '0;
      gnt_vld = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (!gnt_vld && rot[k]) begin
            gnt     = IDW'((int'(start) + k) % NREQ);
            gnt_vld = 1'b1;
         end
      end
   end

   assign accept = (state == S_IDLE) && gnt_vld;

   // One-hot accept strobe, forced low while reset is asserted
   always_comb begin
      REQ_READY = '0;
      if (accept && !RESET)
         REQ_READY[gnt] = 1'b1;
   end

   // Next-state logic for the IDLE -> ISSUE -> RESP sequence
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (gnt_vld) state_nxt = S_ISSUE;
         S_ISSUE: state_nxt = S_RESP;
         S_RESP:  if (RSP_READY) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   // Capture the granted requester's operands and index at accept
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         op_a <= 1'b0;
         op_b <= 1'b0;
         id   <= '0;
      end else if (accept) begin
         op_a <= REQ_A[gnt];
         op_b <= REQ_B[gnt];
         id   <= gnt;
      end
   end

   // The unit only samples in ISSUE, so XOR_O holds steady throughout RESP
   assign XOR_CE    = (state == S_ISSUE);
   assign XOR_A     = op_a;
   assign XOR_B     = op_b;
   assign RSP_VALID = (state == S_RESP);
   assign RSP_DATA  = RSP_VALID & XOR_O;
   assign RSP_ID    = RSP_VALID ? id : '0;

endmodule

// File: tb/tb_my_xor2_rr_arbiter.sv
// Bench for my_xor2_rr_arbiter: directed vectors, expected responses queued
// by the stimulus and popped by an independent response monitor.
`timescale 1ns/1ps
module tb_my_xor2_rr_arbiter;
   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic            CLK = 1'b0;
   logic            RESET;
   logic [NREQ-1:0] REQ_VALID, REQ_A, REQ_B, REQ_READY;
   logic            XOR_CE, XOR_A, XOR_B, XOR_O;
   logic            RSP_VALID, RSP_DATA, RSP_READY;
   logic [IDW-1:0]  RSP_ID;

   int         n_chk = 0;
   int         n_fail = 0;
   int         cyc = 0;
   logic [2:0] exp_q[$];
   logic [2:0] mon_e;

   my_xor2_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
      .CLK(CLK), .RESET(RESET), .REQ_VALID(REQ_VALID), .REQ_A(REQ_A),
      .REQ_B(REQ_B), .REQ_READY(REQ_READY), .XOR_CE(XOR_CE), .XOR_A(XOR_A),
      .XOR_B(XOR_B), .XOR_O(XOR_O), .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA),
      .RSP_ID(RSP_ID), .RSP_READY(RSP_READY));

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   // Shared registered XOR unit
   always @(posedge CLK or posedge RESET) begin
      if (RESET)       XOR_O <= 1'b0;
      else if (XOR_CE) XOR_O <= XOR_A ^ XOR_B;
   end

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_outs_zero(input string name);
      chk(name, int'({REQ_READY, XOR_CE, XOR_A, XOR_B, RSP_VALID, RSP_DATA, RSP_ID}), 0);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   // Wait (bounded) for a cycle in which some REQ_READY bit is high
   task automatic wait_grant(output logic [NREQ-1:0] rr, output int c);
      rr = '0;
      c  = cyc;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         if (REQ_READY != '0) begin
            rr = REQ_READY;
            c  = cyc;
            return;
         end
      end
   endtask

   // Response monitor: every accepted response must match the queue head
   always @(negedge CLK) begin
      if (!RESET && RSP_VALID && RSP_READY) begin
         if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_rsp: got id=%0d data=%0d, expected no response", RSP_ID, RSP_DATA);
         end else begin
            mon_e = exp_q.pop_front();
            chk("rsp_id", int'(RSP_ID), int'(mon_e[2:1]));
            chk("rsp_data", int'(RSP_DATA), int'(mon_e[0]));
         end
      end
   end

   initial begin
      #100us;
      $display("FAIL watchdog: got timeout, expected test completion");
      $fatal(1);
   end

   initial begin
      logic [NREQ-1:0] rr;
      int c, c0, cprev;
      int ids[5]   = '{0, 1, 2, 3, 0};
      logic pa[4]  = '{1'b0, 1'b0, 1'b1, 1'b1};
      logic pb[4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic ed[4]  = '{1'b0, 1'b1, 1'b1, 1'b0};

      RESET = 1'b1; REQ_VALID = 4'b1111; REQ_A = 4'b1111; REQ_B = 4'b0000; RSP_READY = 1'b1;
      @(negedge CLK);
      chk_outs_zero("reset_outs");
      chk("reset_xor_o", int'(XOR_O), 0);
      @(posedge CLK); #1;
      RESET = 1'b0; REQ_VALID = 4'b0000;
      idle(1);

`ifdef MY_XOR2_ARB_FIXED_PRIO_EN
      // Fixed priority: requester 1 always beats requester 3
      REQ_VALID = 4'b1010; REQ_A = 4'b0010; REQ_B = 4'b1000;
      for (int k = 0; k < 3; k++) exp_q.push_back(3'b011);
      exp_q.push_back(3'b111);
      for (int k = 0; k < 3; k++) begin
         wait_grant(rr, c);
         chk("fixed_grant1", int'(rr), 2);
         @(posedge CLK); #1;
      end
      REQ_VALID = 4'b1000;
      wait_grant(rr, c);
      chk("fixed_grant3", int'(rr), 8);
      @(posedge CLK); #1;
      REQ_VALID = 4'b0000;
      idle(4);
`else
      // Fairness: all valid, A=i[0], B=1
      REQ_VALID = 4'b1111; REQ_A = 4'b1010; REQ_B = 4'b1111;
      exp_q.push_back(3'b001); exp_q.push_back(3'b010); exp_q.push_back(3'b101);
      exp_q.push_back(3'b110); exp_q.push_back(3'b001);
      cprev = 0;
      for (int k = 0; k < 5; k++) begin
         wait_grant(rr, c);
         chk("fair_grant", int'(rr), 1 << ids[k]);
         if (k > 0) chk("fair_period", c - cprev, 3);
         cprev = c;
         @(posedge CLK); #1;
      end
      REQ_VALID = 4'b0000;
      idle(3);

      // Single requester 2, A=1 B=0
      REQ_VALID = 4'b0100; REQ_A = 4'b0100; REQ_B = 4'b0000;
      exp_q.push_back(3'b101);
      wait_grant(rr, c0);
      chk("single_grant", int'(rr), 4);
      @(posedge CLK); #1;
      REQ_VALID = 4'b0000;
      @(negedge CLK);
      chk("single_issue_ce", int'(XOR_CE), 1);
      chk("single_issue_ready", int'(REQ_READY), 0);
      chk("single_issue_rspv", int'(RSP_VALID), 0);
      @(negedge CLK);
      chk("single_rsp_valid", int'(RSP_VALID), 1);
      chk("single_rsp_ce", int'(XOR_CE), 0);
      chk("single_latency", cyc - c0, 2);
      idle(2);

      // Backpressure: requesters 1 and 3, pointer now at 3
      RSP_READY = 1'b0;
      REQ_VALID = 4'b1010; REQ_A = 4'b1010; REQ_B = 4'b0010;
      exp_q.push_back(3'b111); exp_q.push_back(3'b010);
      wait_grant(rr, c);
      chk("bp_grant3", int'(rr), 8);
      @(posedge CLK); #1;
      @(negedge CLK);
      for (int k = 0; k < 5; k++) begin
         @(negedge CLK);
         chk("bp_valid", int'(RSP_VALID), 1);
         chk("bp_data", int'(RSP_DATA), 1);
         chk("bp_id", int'(RSP_ID), 3);
         chk("bp_ce", int'(XOR_CE), 0);
         chk("bp_ready", int'(REQ_READY), 0);
      end
      @(posedge CLK); #1;
      RSP_READY = 1'b1;
      wait_grant(rr, c);
      chk("bp_next_grant1", int'(rr), 2);
      @(posedge CLK); #1;
      REQ_VALID = 4'b0000;
      idle(3);

      // Operand patterns on requester 0
      for (int p = 0; p < 4; p++) begin
         REQ_A = {3'b000, pa[p]}; REQ_B = {3'b000, pb[p]};
         REQ_VALID = 4'b0001;
         exp_q.push_back({2'b00, ed[p]});
         wait_grant(rr, c);
         chk("op_grant0", int'(rr), 1);
         @(posedge CLK); #1;
         REQ_VALID = 4'b0000;
         idle(3);
      end

      // Reset while in ISSUE: request dropped, pointer back to 0
      REQ_VALID = 4'b0100; REQ_A = 4'b0100; REQ_B = 4'b0000;
      wait_grant(rr, c);
      chk("rst_pre_grant2", int'(rr), 4);
      @(posedge CLK); #1;
      REQ_VALID = 4'b0000;
      #2;
      RESET = 1'b1;
      #0.05;
      chk_outs_zero("rst_issue_outs");
      chk("rst_issue_xor_o", int'(XOR_O), 0);
      #0.05;
      RESET = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge CLK);
         chk("rst_no_rsp", int'(RSP_VALID), 0);
      end
      @(posedge CLK); #1;
      REQ_VALID = 4'b1001; REQ_A = 4'b0001; REQ_B = 4'b0000;
      exp_q.push_back(3'b001);
      wait_grant(rr, c);
      chk("rst_next_grant0", int'(rr), 1);
      @(posedge CLK); #1;
      REQ_VALID = 4'b0000;
      idle(4);
`endif

      chk("queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/my_xor2_rr_arbiter.md
# my_xor2_rr_arbiter

Round-robin arbiter and sequencer that shares one registered XOR unit (MY_XOR2_WDFF-style: operands sampled on CLK when CE=1, result on O one cycle later, held while CE=0) among NREQ requesters. It accepts one operand pair per transaction through a valid/ready handshake and drives the unit's CE and operands. It returns the result with the requester's index through a valid/ready response port. It sits between the requesting control logic and the single shared XOR datapath.

## Interface
- NREQ, 4: number of requesters, 2..8.
- IDW, 2: width of the requester index, equal to clog2(NREQ) and at least 1.
- CLK  input  1  single clock; all state changes on the rising edge.
- RESET  input  1  asynchronous, active-high reset; also wired to the shared unit's RESET.
- REQ_VALID  input  NREQ  per-requester request valid.
- REQ_A  input  NREQ  operand A, bit i belongs to requester i.
- REQ_B  input  NREQ  operand B, bit i belongs to requester i.
- REQ_READY  output  NREQ  one-hot accept strobe; at most one bit high.
- XOR_CE  output  1  clock enable to the shared unit.
- XOR_A  output  1  operand A to the shared unit.
- XOR_B  output  1  operand B to the shared unit.
- XOR_O  input  1  registered result from the shared unit.
- RSP_VALID  output  1  result available.
- RSP_DATA  output  1  XOR result.
- RSP_ID  output  IDW  index of the requester that owns RSP_DATA.
- RSP_READY  input  1  consumer accepts the response.

## Operation
- FSM states: IDLE, ISSUE, RESP. Reset state is IDLE.
- IDLE
  - If any REQ_VALID is high, grant g = first set bit searching upward from pointer PTR, wrapping modulo NREQ.
  - REQ_READY[g]=1 combinationally in this cycle only.
  - Latch REQ_A[g], REQ_B[g] and g into the operand and ID registers, then go to ISSUE.
  - If no REQ_VALID is high, stay in IDLE.
- ISSUE
  - XOR_CE=1, XOR_A and XOR_B come from the operand registers.
  - Go to RESP unconditionally.
- RESP
  - RSP_VALID=1, RSP_DATA=XOR_O, RSP_ID=latched g.
  - XOR_CE=0 here, so XOR_O stays stable for as long as the state is held.
  - When RSP_READY=1: PTR <= (g+1) mod NREQ, then go to IDLE.
  - Otherwise hold, with all response outputs stable.
- REQ_READY is 0 in ISSUE and RESP. Only one transaction is in flight at a time.
- A requester whose REQ_VALID drops before it is granted is simply skipped. No request is lost once REQ_READY has been asserted, except on reset.
- Reset values: state IDLE, PTR=0, operand, ID and response registers 0. All outputs are 0: REQ_READY, XOR_CE, XOR_A, XOR_B, RSP_VALID, RSP_DATA and RSP_ID.
- Reset mid-operation: an in-flight transaction is dropped with no response. The shared unit is reset by the same RESET, so XOR_O=0.

## Timing
- Accept at edge T (REQ_READY high in cycle T-1→T). XOR_CE is high in cycle T→T+1. RSP_VALID is high from T+1 (result sampled by the unit at edge T+1).
- Request-to-response latency is 2 cycles, measured from the accept cycle to the first RSP_VALID cycle.
- Minimum transaction period is 3 cycles when RSP_READY is held high.
- Fairness: with all NREQ requesters continuously valid, each is granted once every NREQ transactions.
- RSP_READY asserted in the first RESP cycle completes the response in that cycle. IDLE may accept a new request in the very next cycle.

## Configuration
- MY_XOR2_ARB_FIXED_PRIO_EN
  - Defined: fixed priority, lowest index wins. PTR is not implemented and the search always starts at 0.
  - Undefined (default): round-robin as described above.

## Test plan
- Single requester: NREQ=4, requester 2 sends A=1,B=0 -> REQ_READY=4'b0100 for one cycle; 2 cycles later RSP_VALID=1, RSP_DATA=1, RSP_ID=2.
- All four valid continuously with A=i[0], B=1, RSP_READY=1 -> grant order 0,1,2,3,0; RSP_DATA sequence 1,0,1,0,1; a new transaction every 3 cycles.
- Backpressure: hold RSP_READY=0 for 5 cycles during RESP -> RSP_VALID/DATA/ID stable, XOR_CE=0, REQ_READY=0 throughout; release -> PTR advances and the next requester is granted.
- Operand patterns: for each of (0,0),(0,1),(1,0),(1,1) on requester 0 -> RSP_DATA = 0,1,1,0.
- Reset in ISSUE: assert RESET for 100 ps mid-cycle -> every output 0 immediately, no RSP_VALID for the dropped request, and the next grant starts at requester 0.
- With MY_XOR2_ARB_FIXED_PRIO_EN defined, requesters 1 and 3 continuously valid -> requester 1 is always granted and requester 3 never until requester 1 drops REQ_VALID.
